// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port sequencer: shares the byte-wide synchronous-read memory between
// the loader (byte writes) and the fetch stage (four-beat big-endian word reads).
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [63:0]       fetch_addr,
    output logic              fetch_busy,
    output logic              fetch_valid,
    output logic              fetch_err,
    output logic [31:0]       instruction,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StCap, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] base_q, base_d;
    logic [23:0] slots_q, slots_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        slots_d   = slots_q;
        instr_d   = instr_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        load_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_we) begin
                    // Loader wins the port; a concurrent fetch_req waits for a free cycle.
                    mem_we    = 1'b1;
                    mem_addr  = load_addr;
                    mem_wdata = load_data;
                    load_ack  = 1'b1;
                end else if (fetch_req) begin
                    base_d = fetch_addr;
                    cnt_d  = '0;
                    if (fetch_addr[1:0] != 2'b00 || (fetch_addr >> ADDR_W) != 64'd0) begin
                        err_d   = 1'b1;
                        instr_d = '0;
                        valid_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                mem_addr = base_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
                // Read data lags the address by one beat, so beat n captures byte n-1.
                unique case (cnt_q)
                    2'd1:    slots_d[23:16] = mem_rdata;
                    2'd2:    slots_d[15:8]  = mem_rdata;
                    2'd3:    slots_d[7:0]   = mem_rdata;
                    default: ;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StCap;
                end
            end
            StCap: begin
                instr_d = {slots_q, mem_rdata};
                valid_d = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            slots_q <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            slots_q <= slots_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign fetch_busy  = (state_q != StIdle);
    assign fetch_valid = valid_q;
    assign fetch_err   = valid_q & err_q;
    assign instruction = instr_q;

endmodule
